alu_issue_sched: RTL and testbench

Issue scheduler for the single ALU functional unit. Buffers dispatched ALU micro-ops (rs_data) and tracks source-operand readiness from writeback broadcasts. Each cycle it selects the oldest ready entry and issues it to the ALU together with PRF read addresses. Squashes younger-than-branch entries on ROB mispredict; sits between rename/dispatch and the PRF read stage feeding fu_alu.

---
 rtl/alu_issue_sched.sv | 228 ++++++++++++++++++++++
 tb/tb_alu_issue_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_sched.sv
// ---------------------------------------------------------------------------
// alu_issue_sched
//
// Issue scheduler for the single ALU. Holds dispatched micro-ops, tracks
// source readiness from writeback broadcasts, and each cycle issues the
// oldest ready entry (by dispatch order) to the ALU. Entries younger than a
// mispredicted branch are squashed on a ROB flush.
//
// Micro-op layout (MSB..LSB), width 3*PREG_W+54:
//   pd | ps1 | ps2 | rob_index[4:0] | opcode[6:0] | func3[2:0] | func7[6:0] | imm[31:0]
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   disp_valid/ready    dispatch handshake; disp_data is the micro-op
//   disp_ps1/2_rdy      source already present in the PRF
//   wb_valid/wb_preg    NWB wakeup broadcast ports
//   fu_ready            ALU can accept an issue this cycle
//   issued/issue_data   registered issue output
//   prf_ra1/prf_ra2     PRF read addresses taken from issue_data
//   curr_rob_tag        ROB tail (exclusive end of flush range)
//   mispredict(_tag)    one-cycle flush strobe and branch ROB tag
//   occupancy           registered count of valid entries
// ---------------------------------------------------------------------------
module alu_issue_sched #(
  parameter int DEPTH    = 8,
  parameter int PREG_W   = 7,
  parameter int NWB      = 2,
  parameter int ROB_SIZE = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    disp_valid,
  output logic                    disp_ready,
  input  logic [3*PREG_W+53:0]    disp_data,
  input  logic                    disp_ps1_rdy,
  input  logic                    disp_ps2_rdy,
  input  logic [NWB-1:0]          wb_valid,
  input  logic [NWB*PREG_W-1:0]   wb_preg,
  input  logic                    fu_ready,
  output logic                    issued,
  output logic [3*PREG_W+53:0]    issue_data,
  output logic [PREG_W-1:0]       prf_ra1,
  output logic [PREG_W-1:0]       prf_ra2,
  input  logic [4:0]              curr_rob_tag,
  input  logic                    mispredict,
  input  logic [4:0]              mispredict_tag,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int RS_W    = 3*PREG_W + 54;
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int CNT_W   = IDX_W + 1;
  localparam int ROB_LSB = 49;
  localparam int PS2_LSB = 54;
  localparam int PS1_LSB = 54 + PREG_W;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rdy1_q, rdy1_d;
  logic [DEPTH-1:0] rdy2_q, rdy2_d;
  logic [RS_W-1:0]  ent_q [DEPTH];
  logic [RS_W-1:0]  ent_d [DEPTH];
  // older_q[i][j] set: entry i was dispatched before entry j. Only rows and
  // columns of valid entries are meaningful; a slot's row/column is rewritten
  // whenever it is allocated.
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  logic             issued_q, issued_d;
  logic [RS_W-1:0]  issue_data_q, issue_data_d;
  logic [CNT_W-1:0] occ_q, occ_d;

  logic [DEPTH-1:0] flush;
  logic [DEPTH-1:0] elig;
  logic [DEPTH-1:0] pick;
  logic             sel_vld;
  logic [IDX_W-1:0] sel_idx;
  logic             has_free;
  logic [IDX_W-1:0] free_idx;
  logic             disp_fire;

  function automatic logic wb_hit(input logic [PREG_W-1:0]     tag,
                                  input logic [NWB-1:0]        v,
                                  input logic [NWB*PREG_W-1:0] p);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NWB; k++) begin
      if (v[k] && (p[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Circular range (mtag+1 .. curr-1). Distances are taken from the range
  // start so wrap-around of ROB tags needs no special casing.
  function automatic logic in_flush(input logic [4:0] tag,
                                    input logic [4:0] mtag,
                                    input logic [4:0] curr);
    int s;
    int dt;
    int dc;
    s  = (int'(mtag) + 1) % ROB_SIZE;
    dt = (int'(tag)  - s + ROB_SIZE) % ROB_SIZE;
    dc = (int'(curr) - s + ROB_SIZE) % ROB_SIZE;
    return dt < dc;
  endfunction

  assign disp_ready = (occ_q < CNT_W'(DEPTH)) && !mispredict;
  assign disp_fire  = disp_valid && disp_ready && has_free;

  always_comb begin
    flush = '0;
    elig  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      flush[i] = mispredict && valid_q[i] &&
                 in_flush(ent_q[i][ROB_LSB +: 5], mispredict_tag, curr_rob_tag);
      elig[i]  = valid_q[i] && rdy1_q[i] && rdy2_q[i] && !flush[i];
    end
  end

  // An eligible entry is picked only if no other eligible entry is older.
  always_comb begin
    pick = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pick[i] = elig[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (elig[j] && older_q[j][i]) pick[i] = 1'b0;
      end
    end
  end

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (pick[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    valid_d      = valid_q;
    rdy1_d       = rdy1_q;
    rdy2_d       = rdy2_q;
    ent_d        = ent_q;
    older_d      = older_q;
    issued_d     = 1'b0;
    issue_data_d = issue_data_q;

    if (fu_ready && sel_vld) begin
      issued_d         = 1'b1;
      issue_data_d     = ent_q[sel_idx];
      valid_d[sel_idx] = 1'b0;
    end

    valid_d = valid_d & ~flush;

    for (int i = 0; i < DEPTH; i++) begin
      if (wb_hit(ent_q[i][PS1_LSB +: PREG_W], wb_valid, wb_preg)) rdy1_d[i] = 1'b1;
      if (wb_hit(ent_q[i][PS2_LSB +: PREG_W], wb_valid, wb_preg)) rdy2_d[i] = 1'b1;
    end

    // A new entry is youngest: older than nothing, younger than every slot.
    if (disp_fire) begin
      valid_d[free_idx] = 1'b1;
      ent_d[free_idx]   = disp_data;
      rdy1_d[free_idx]  = disp_ps1_rdy ||
                          wb_hit(disp_data[PS1_LSB +: PREG_W], wb_valid, wb_preg);
      rdy2_d[free_idx]  = disp_ps2_rdy ||
                          wb_hit(disp_data[PS2_LSB +: PREG_W], wb_valid, wb_preg);
      older_d[free_idx] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != int'(free_idx)) older_d[j][free_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + CNT_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q      <= '0;
      rdy1_q       <= '0;
      rdy2_q       <= '0;
      issued_q     <= 1'b0;
      issue_data_q <= '0;
      occ_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i]   <= '0;
        older_q[i] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      rdy1_q       <= rdy1_d;
      rdy2_q       <= rdy2_d;
      issued_q     <= issued_d;
      issue_data_q <= issue_data_d;
      occ_q        <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i]   <= ent_d[i];
        older_q[i] <= older_d[i];
      end
    end
  end

  assign issued     = issued_q;
  assign issue_data = issue_data_q;
  assign occupancy  = occ_q;
  assign prf_ra1    = issue_data_q[PS1_LSB +: PREG_W];
  assign prf_ra2    = issue_data_q[PS2_LSB +: PREG_W];

endmodule

// File: tb/tb_alu_issue_sched.sv
module tb_alu_issue_sched;
  localparam int DEPTH    = 8;
  localparam int PREG_W   = 7;
  localparam int NWB      = 2;
  localparam int ROB_SIZE = 16;
  localparam int RS_W     = 3*PREG_W + 54;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  disp_valid;
  logic                  disp_ready;
  logic [RS_W-1:0]       disp_data;
  logic                  disp_ps1_rdy;
  logic                  disp_ps2_rdy;
  logic [NWB-1:0]        wb_valid;
  logic [NWB*PREG_W-1:0] wb_preg;
  logic                  fu_ready;
  logic                  issued;
  logic [RS_W-1:0]       issue_data;
  logic [PREG_W-1:0]     prf_ra1;
  logic [PREG_W-1:0]     prf_ra2;
  logic [4:0]            curr_rob_tag;
  logic                  mispredict;
  logic [4:0]            mispredict_tag;
  logic [3:0]            occupancy;

  alu_issue_sched #(.DEPTH(DEPTH), .PREG_W(PREG_W), .NWB(NWB), .ROB_SIZE(ROB_SIZE)) dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_data(disp_data),
    .disp_ps1_rdy(disp_ps1_rdy), .disp_ps2_rdy(disp_ps2_rdy),
    .wb_valid(wb_valid), .wb_preg(wb_preg), .fu_ready(fu_ready),
    .issued(issued), .issue_data(issue_data), .prf_ra1(prf_ra1), .prf_ra2(prf_ra2),
    .curr_rob_tag(curr_rob_tag), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RS_W-1:0] d;
    bit              r1;
    bit              r2;
  } ment_t;

  ment_t           mq[$];          // live entries, oldest dispatch first
  bit              exp_issued = 1'b0;
  logic [RS_W-1:0] exp_data   = '0;
  int              n_chk  = 0;
  int              n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] rob_of(input logic [RS_W-1:0] d);
    return d[53:49];
  endfunction
  function automatic logic [6:0] ps1_of(input logic [RS_W-1:0] d);
    return d[61 +: 7];
  endfunction
  function automatic logic [6:0] ps2_of(input logic [RS_W-1:0] d);
    return d[54 +: 7];
  endfunction

  function automatic logic [RS_W-1:0] mk(input int pd, input int ps1, input int ps2, input int rob);
    logic [RS_W-1:0] d;
    d = '0;
    d[31:0]  = $urandom;
    d[38:32] = 7'($urandom);
    d[41:39] = 3'($urandom);
    d[48:42] = 7'($urandom);
    d[53:49] = 5'(rob);
    d[54+:7] = 7'(ps2);
    d[61+:7] = 7'(ps1);
    d[68+:7] = 7'(pd);
    return d;
  endfunction

  function automatic bit wb_hit(input logic [6:0] p);
    bit h;
    h = 0;
    for (int k = 0; k < NWB; k++)
      if (wb_valid[k] && wb_preg[k*PREG_W +: PREG_W] == p) h = 1;
    return h;
  endfunction

  // Called at a negedge with this cycle's inputs already driven. Checks
  // disp_ready, advances the model over the edge, then checks the
  // registered outputs at the following negedge and clears one-shot inputs.
  task automatic step();
    bit    rdy;
    int    sel;
    bit [15:0] fr;
    int    mt;
    int    cu;
    ment_t e;
    #1;
    rdy = (mq.size() < DEPTH) && !mispredict;
    chk("disp_ready", disp_ready, rdy);
    fr = '0;
    if (mispredict) begin
      mt = int'(mispredict_tag);
      cu = int'(curr_rob_tag) % ROB_SIZE;
      for (int t = (mt + 1) % ROB_SIZE; t != cu; t = (t + 1) % ROB_SIZE) fr[t] = 1'b1;
    end
    sel = -1;
    if (fu_ready)
      for (int i = 0; i < mq.size(); i++)
        if (sel < 0 && mq[i].r1 && mq[i].r2 && !fr[int'(rob_of(mq[i].d))]) sel = i;
    exp_issued = (sel >= 0);
    if (sel >= 0) begin
      exp_data = mq[sel].d;
      mq.delete(sel);
    end
    for (int i = mq.size() - 1; i >= 0; i--)
      if (fr[int'(rob_of(mq[i].d))]) mq.delete(i);
    for (int i = 0; i < mq.size(); i++) begin
      if (wb_hit(ps1_of(mq[i].d))) mq[i].r1 = 1;
      if (wb_hit(ps2_of(mq[i].d))) mq[i].r2 = 1;
    end
    if (disp_valid && rdy) begin
      e.d  = disp_data;
      e.r1 = disp_ps1_rdy || wb_hit(ps1_of(disp_data));
      e.r2 = disp_ps2_rdy || wb_hit(ps2_of(disp_data));
      mq.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    chk("issued", issued, exp_issued);
    chk("issue_data", issue_data, exp_data);
    chk("occupancy", occupancy, mq.size());
    chk("prf_ra1", prf_ra1, ps1_of(exp_data));
    chk("prf_ra2", prf_ra2, ps2_of(exp_data));
    disp_valid = 1'b0;
    wb_valid   = '0;
    mispredict = 1'b0;
  endtask

  task automatic disp(input logic [RS_W-1:0] d, input bit r1, input bit r2);
    disp_valid   = 1'b1;
    disp_data    = d;
    disp_ps1_rdy = r1;
    disp_ps2_rdy = r2;
    step();
  endtask

  task automatic wake0(input int p);
    wb_valid = 2'b01;
    wb_preg  = {7'd0, 7'(p)};
    step();
  endtask

  int  tail;
  bit  acc;
  bit  mp;
  bit  win_ok;
  int  mt_r;

  initial begin
    reset = 1'b0;
    disp_valid = 1'b0; disp_data = '0; disp_ps1_rdy = 1'b0; disp_ps2_rdy = 1'b0;
    wb_valid = '0; wb_preg = '0; fu_ready = 1'b1;
    curr_rob_tag = 5'd0; mispredict = 1'b0; mispredict_tag = 5'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_issued", issued, 0);
    chk("rst_issue_data", issue_data, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_disp_ready", disp_ready, 1);

    // 1: single ready op issues one cycle after dispatch
    disp(mk(1, 10, 11, 3), 1, 1);
    chk("t1_occ_after_disp", occupancy, 1);
    chk("t1_not_yet", issued, 0);
    step();
    chk("t1_issued", issued, 1);
    chk("t1_rob", issue_data[53:49], 3);
    chk("t1_occ_after_issue", occupancy, 0);

    // 2: younger ready op bypasses older waiting op
    disp(mk(2, 20, 11, 4), 0, 1);
    disp(mk(3, 12, 13, 5), 1, 1);
    step();
    chk("t2_first_rob", issue_data[53:49], 5);
    wake0(20);
    chk("t2_wake_cycle_idle", issued, 0);
    step();
    chk("t2_second_issued", issued, 1);
    chk("t2_second_rob", issue_data[53:49], 4);

    // 3: same-cycle wakeup bypass on port 1
    wb_valid = 2'b10;
    wb_preg  = {7'd21, 7'd0};
    disp(mk(4, 14, 21, 6), 1, 0);
    step();
    chk("t3_issued", issued, 1);
    chk("t3_rob", issue_data[53:49], 6);

    // 4: fill all slots with waiting ops
    for (int i = 0; i < 8; i++) disp(mk(5, 40 + i, 11, (7 + i) % 16), 0, 1);
    chk("t4_occ_full", occupancy, 8);
    #1 chk("t4_full_not_ready", disp_ready, 0);
    wake0(40);
    step();
    chk("t4_one_issued", issued, 1);
    chk("t4_rob", issue_data[53:49], 7);
    chk("t4_occ", occupancy, 7);
    #1 chk("t4_ready_again", disp_ready, 1);
    for (int i = 1; i < 8; i++) wake0(40 + i);
    repeat (3) step();
    chk("t4_drained", occupancy, 0);

    // 5: flush across ROB tag wrap
    disp(mk(6, 50, 11, 14), 0, 1);
    disp(mk(6, 50, 11, 15), 0, 1);
    disp(mk(6, 50, 11, 0), 0, 1);
    disp(mk(6, 50, 11, 1), 0, 1);
    mispredict = 1'b1; mispredict_tag = 5'd14; curr_rob_tag = 5'd2;
    #1 chk("t5_ready_in_flush", disp_ready, 0);
    step();
    chk("t5_occ_after_flush", occupancy, 1);
    wake0(50);
    step();
    chk("t5_survivor_rob", issue_data[53:49], 14);
    step();
    chk("t5_empty", occupancy, 0);

    // 6: ALU stall, then strict dispatch-order drain
    fu_ready = 1'b0;
    disp(mk(7, 1, 2, 2), 1, 1);
    disp(mk(7, 3, 4, 3), 1, 1);
    disp(mk(7, 5, 6, 4), 1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_stalled", issued, 0);
    end
    fu_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_order_issued", issued, 1);
      chk("t6_order_rob", issue_data[53:49], 2 + i);
    end

    // randomized traffic against the model
    tail = 5;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        #2 reset = 1'b0;
        #1;
        chk("async_rst_occ", occupancy, 0);
        chk("async_rst_issued", issued, 0);
        chk("async_rst_data", issue_data, 0);
        mq.delete();
        exp_issued = 1'b0;
        exp_data   = '0;
        @(negedge clk);
        reset = 1'b1;
        continue;
      end
      fu_ready = ($urandom_range(0, 9) < 8);
      mp = ($urandom_range(0, 19) == 0);
      mt_r = (tail + 2*ROB_SIZE - 1 - int'($urandom_range(0, 7))) % ROB_SIZE;
      mispredict     = mp;
      mispredict_tag = 5'(mt_r);
      curr_rob_tag   = 5'(tail);
      win_ok = (mq.size() == 0) ||
               (((tail - int'(rob_of(mq[0].d)) + ROB_SIZE) % ROB_SIZE) < 15);
      disp_valid   = win_ok && ($urandom_range(0, 9) < 6);
      disp_data    = mk($urandom_range(0, 127), $urandom_range(0, 15), $urandom_range(0, 15), tail);
      disp_ps1_rdy = $urandom_range(0, 1);
      disp_ps2_rdy = $urandom_range(0, 1);
      wb_valid     = 2'($urandom_range(0, 3));
      wb_preg      = {7'($urandom_range(0, 15)), 7'($urandom_range(0, 15))};
      acc = disp_valid && !mp && (mq.size() < DEPTH);
      step();
      if (mp) tail = (mt_r + 1) % ROB_SIZE;
      else if (acc) tail = (tail + 1) % ROB_SIZE;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
